ram_mfc_responder: RTL and testbench

Memory-side responder for the CPU's MFA/MFC memory handshake, the counterpart of the control unit's ramMFA/ramRW/ramDataSize/ramAddress request outputs. It latches a request, waits a programmable access latency and commits the write or drives the read data. It then asserts MFC and holds it until the control unit drops MFA (four-phase, fully interlocked). Storage is a byte-addressed, big-endian array sitting between the datapath MAR/MDR and the control unit.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_size_align.sv | 46 ++++
 rtl/ram_mfc_responder.sv | 152 +++++++++++++++
 tb/tb_ram_mfc_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared encodings for the MFA/MFC memory responder: access sizes, handshake
// states and the read/write flag as driven by the control unit.
package ram_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ram_size_align.sv
// Size/alignment decode: byte enables, error flag, big-endian read steering
// (zero-extended) and write-lane placement. Enable bit i refers to byte A+i.
module ram_size_align
  import ram_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw_rd,
  input  logic [31:0] wr_in,
  output logic [3:0]  be,
  output logic        err,
  output logic [31:0] rd_out,
  output logic [31:0] wr_lanes
);

  always_comb begin
    be       = '0;
    err      = 1'b1;
    rd_out   = '0;
    wr_lanes = '0;
    case (size)
      SIZE_BYTE: begin
        err      = 1'b0;
        be       = 4'b0001;
        rd_out   = {24'h0, raw_rd[31:24]};
        wr_lanes = {wr_in[7:0], 24'h0};
      end
      SIZE_HALF: begin
        err      = addr_lo[0];
        be       = addr_lo[0] ? 4'b0000 : 4'b0011;
        rd_out   = {16'h0, raw_rd[31:16]};
        wr_lanes = {wr_in[15:0], 16'h0};
      end
      SIZE_WORD: begin
        err      = |addr_lo;
        be       = (|addr_lo) ? 4'b0000 : 4'b1111;
        rd_out   = raw_rd;
        wr_lanes = wr_in;
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ram_mfc_responder.sv
// Memory-side responder for the MFA/MFC four-phase handshake: latches a request,
// waits LATENCY edges, commits the write or drives read data, then holds MFC.
module ram_mfc_responder
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int LATENCY    = 2
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  ramMFA,
  input  logic                  ramRW,
  input  logic [1:0]            ramDataSize,
  input  logic [ADDR_WIDTH-1:0] ramAddress,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  ramMFC,
  output logic                  ramErr
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rw_q, rw_d;
  logic [1:0]              size_q, size_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    mfc_q, mfc_d;
  logic                    err_q, err_d;
  logic                    mem_we;

  logic [7:0]  mem [DEPTH];
  logic [31:0] raw_rd;
  logic [3:0]  be;
  logic        acc_err;
  logic [31:0] rd_steered;
  logic [31:0] wr_lanes;

  // Four bytes starting at the latched address, MSB first; the decoder picks
  // how many of them matter.
  always_comb begin
    raw_rd = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      raw_rd[31-8*i -: 8] = mem[addr_q + ADDR_WIDTH'(i)];
    end
  end

  ram_size_align u_size_align (
    .size     (size_q),
    .addr_lo  (addr_q[1:0]),
    .raw_rd   (raw_rd),
    .wr_in    (wdata_q),
    .be       (be),
    .err      (acc_err),
    .rd_out   (rd_steered),
    .wr_lanes (wr_lanes)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ramMFA) begin
          rw_d    = ramRW;
          size_d  = ramDataSize;
          addr_d  = ramAddress;
          wdata_d = dataIn;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!ramMFA) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_DONE;
          mfc_d   = 1'b1;
          err_d   = acc_err;
          if (rw_q == RW_READ) begin
            dout_d = acc_err ? '0 : rd_steered;
          end else begin
            mem_we = !acc_err;
          end
        end
      end
      ST_DONE: begin
        if (!ramMFA) begin
          mfc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= RW_WRITE;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
    end
  end

  // Storage is never cleared; the write strobe comes from state that reset
  // forces to IDLE, so an interrupted access leaves memory untouched.
  always_ff @(posedge Clk) begin
    if (mem_we && reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr_q + ADDR_WIDTH'(i)] <= wr_lanes[31-8*i -: 8];
        end
      end
    end
  end

  assign dataOut = dout_q;
  assign ramMFC  = mfc_q;
  assign ramErr  = err_q;

endmodule

// File: tb/tb_ram_mfc_responder.sv
// Directed bench for ram_mfc_responder (LATENCY=2): handshake timing, big-endian
// sub-word access, alignment errors, abort and reset behaviour.
module tb_ram_mfc_responder;

  logic        Clk;
  logic        reset;
  logic        ramMFA;
  logic        ramRW;
  logic [1:0]  ramDataSize;
  logic [8:0]  ramAddress;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        ramMFC;
  logic        ramErr;

  int total = 0;
  int bad   = 0;

  ram_mfc_responder #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (32),
    .DEPTH      (512),
    .LATENCY    (2)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .ramMFA      (ramMFA),
    .ramRW       (ramRW),
    .ramDataSize (ramDataSize),
    .ramAddress  (ramAddress),
    .dataIn      (dataIn),
    .dataOut     (dataOut),
    .ramMFC      (ramMFC),
    .ramErr      (ramErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Raise MFA with a request and wait (bounded) for MFC; lat = edges from accept.
  task automatic start_xact(input logic rw, input logic [1:0] sz, input logic [8:0] a,
                            input logic [31:0] d, output int lat, output bit seen);
    int n;
    @(negedge Clk);
    ramRW = rw; ramDataSize = sz; ramAddress = a; dataIn = d; ramMFA = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      n++;
      if (ramMFC) seen = 1'b1;
    end
    lat = n - 1;
  endtask

  task automatic end_xact();
    ramMFA = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; ramMFA = 1'b1; ramRW = 1'b0; ramDataSize = 2'b10;
    ramAddress = 9'h100; dataIn = 32'h0;
    repeat (3) @(negedge Clk);
    total++; if (ramMFC !== 1'b0) begin bad++; $display("FAIL rst_mfc got=%b exp=0", ramMFC); end
    total++; if (ramErr !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", ramErr); end
    total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL rst_dout got=%h exp=00000000", dataOut); end
    reset = 1'b1;
    @(negedge Clk);
    total++; if (ramMFC !== 1'b0) begin bad++; $display("FAIL rst_lat_e1 got=%b exp=0", ramMFC); end
    @(negedge Clk);
    total++; if (ramMFC !== 1'b0) begin bad++; $display("FAIL rst_lat_e2 got=%b exp=0", ramMFC); end
    @(negedge Clk);
    total++; if (ramMFC !== 1'b1) begin bad++; $display("FAIL rst_lat_e3 got=%b exp=1", ramMFC); end
    end_xact();
    total++; if (ramMFC !== 1'b0) begin bad++; $display("FAIL rst_drop got=%b exp=0", ramMFC); end
  endtask

  task automatic test_word();
    int lat; bit seen;
    start_xact(1'b0, 2'b10, 9'h010, 32'hDEADBEEF, lat, seen);
    total++; if (!seen || lat != 2) begin bad++; $display("FAIL wr_word_lat got=%0d seen=%0b exp=2", lat, seen); end
    total++; if (ramErr !== 1'b0) begin bad++; $display("FAIL wr_word_err got=%b exp=0", ramErr); end
    end_xact();
    start_xact(1'b1, 2'b10, 9'h010, 32'h0, lat, seen);
    total++; if (!seen || dataOut !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_word got=%h exp=DEADBEEF", dataOut); end
    end_xact();
    start_xact(1'b1, 2'b00, 9'h011, 32'h0, lat, seen);
    total++; if (!seen || dataOut !== 32'h000000AD) begin bad++; $display("FAIL rd_byte got=%h exp=000000AD", dataOut); end
    end_xact();
    start_xact(1'b1, 2'b01, 9'h012, 32'h0, lat, seen);
    total++; if (!seen || dataOut !== 32'h0000BEEF) begin bad++; $display("FAIL rd_half got=%h exp=0000BEEF", dataOut); end
    end_xact();
  endtask

  task automatic test_subword();
    int lat; bit seen;
    start_xact(1'b0, 2'b00, 9'h013, 32'h000000AA, lat, seen);
    end_xact();
    start_xact(1'b0, 2'b01, 9'h010, 32'h00001234, lat, seen);
    end_xact();
    start_xact(1'b1, 2'b10, 9'h010, 32'h0, lat, seen);
    total++; if (!seen || dataOut !== 32'h1234BEAA) begin bad++; $display("FAIL subword_merge got=%h exp=1234BEAA", dataOut); end
    end_xact();
  endtask

  task automatic test_errors();
    int lat; bit seen;
    start_xact(1'b1, 2'b10, 9'h012, 32'h0, lat, seen);
    total++; if (!seen || ramErr !== 1'b1) begin bad++; $display("FAIL err_word_mis got=%b exp=1", ramErr); end
    total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL err_word_dout got=%h exp=00000000", dataOut); end
    total++; if (lat != 2) begin bad++; $display("FAIL err_lat got=%0d exp=2", lat); end
    end_xact();
    total++; if (ramErr !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", ramErr); end
    start_xact(1'b0, 2'b01, 9'h011, 32'h0000FFFF, lat, seen);
    total++; if (!seen || ramErr !== 1'b1) begin bad++; $display("FAIL err_half_mis got=%b exp=1", ramErr); end
    end_xact();
    start_xact(1'b0, 2'b10, 9'h012, 32'hFFFFFFFF, lat, seen);
    total++; if (!seen || ramErr !== 1'b1) begin bad++; $display("FAIL err_word_wr got=%b exp=1", ramErr); end
    end_xact();
    start_xact(1'b0, 2'b11, 9'h010, 32'hFFFFFFFF, lat, seen);
    total++; if (!seen || ramErr !== 1'b1) begin bad++; $display("FAIL err_size11 got=%b exp=1", ramErr); end
    end_xact();
    start_xact(1'b1, 2'b10, 9'h010, 32'h0, lat, seen);
    total++; if (!seen || dataOut !== 32'h1234BEAA || ramErr !== 1'b0) begin
      bad++; $display("FAIL err_no_write got=%h err=%b exp=1234BEAA err=0", dataOut, ramErr);
    end
    end_xact();
  endtask

  task automatic test_abort();
    int lat; bit seen; bit any_mfc;
    start_xact(1'b0, 2'b10, 9'h020, 32'h01020304, lat, seen);
    end_xact();
    @(negedge Clk);
    ramRW = 1'b0; ramDataSize = 2'b10; ramAddress = 9'h020; dataIn = 32'h55555555; ramMFA = 1'b1;
    @(negedge Clk);
    ramMFA = 1'b0;
    any_mfc = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      if (ramMFC) any_mfc = 1'b1;
    end
    total++; if (any_mfc) begin bad++; $display("FAIL abort_mfc got=1 exp=0"); end
    start_xact(1'b1, 2'b10, 9'h020, 32'h0, lat, seen);
    total++; if (!seen || dataOut !== 32'h01020304) begin bad++; $display("FAIL abort_mem got=%h exp=01020304", dataOut); end
    end_xact();
  endtask

  task automatic test_handshake();
    int lat; bit seen;
    start_xact(1'b1, 2'b10, 9'h010, 32'h0, lat, seen);
    ramAddress = 9'h020; ramRW = 1'b0; dataIn = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      total++;
      if (ramMFC !== 1'b1 || dataOut !== 32'h1234BEAA) begin
        bad++; $display("FAIL hold_%0d mfc=%b dout=%h exp mfc=1 dout=1234BEAA", i, ramMFC, dataOut);
      end
    end
    end_xact();
    total++; if (ramMFC !== 1'b0 || dataOut !== 32'h1234BEAA) begin
      bad++; $display("FAIL release mfc=%b dout=%h exp mfc=0 dout=1234BEAA", ramMFC, dataOut);
    end
    start_xact(1'b1, 2'b10, 9'h020, 32'h0, lat, seen);
    total++; if (!seen || dataOut !== 32'h01020304) begin bad++; $display("FAIL hold_no_write got=%h exp=01020304", dataOut); end
    #2 reset = 1'b0;
    #1;
    total++; if (ramMFC !== 1'b0 || ramErr !== 1'b0 || dataOut !== 32'h0) begin
      bad++; $display("FAIL rst_done mfc=%b err=%b dout=%h exp 0 0 00000000", ramMFC, ramErr, dataOut);
    end
    @(negedge Clk);
    ramMFA = 1'b0; reset = 1'b1;
    @(negedge Clk);
    ramRW = 1'b0; ramDataSize = 2'b10; ramAddress = 9'h020; dataIn = 32'hAAAAAAAA; ramMFA = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    #1 reset = 1'b0;
    #1;
    total++; if (ramMFC !== 1'b0) begin bad++; $display("FAIL rst_busy_mfc got=%b exp=0", ramMFC); end
    @(negedge Clk);
    ramMFA = 1'b0; reset = 1'b1;
    start_xact(1'b1, 2'b10, 9'h020, 32'h0, lat, seen);
    total++; if (!seen || dataOut !== 32'h01020304) begin bad++; $display("FAIL rst_busy_mem got=%h exp=01020304", dataOut); end
    end_xact();
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_abort();
    test_handshake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
